// File: rtl/div_pkg.sv
// Shared types and constants for the program-1 divide sequencer.
// Optional rounding state is enabled by defining DIV_ROUND_EN.
package div_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD0,
    ST_RD1,
    ST_RD2,
    ST_CHK,
    ST_DIV,
    ST_RND,
    ST_WR4,
    ST_WR5,
    ST_WR6,
    ST_DONE
  } div_state_e;

  localparam int ADDR_DVD_HI = 0;
  localparam int ADDR_DVD_LO = 1;
  localparam int ADDR_DVS    = 2;
  localparam int ADDR_RES0   = 4;

  localparam int FRAC_BITS = 8;
  localparam int RES_W     = 24;

  localparam logic [RES_W-1:0] DIV_ZERO_RESULT = 24'hFFFFFF;

  // Byte idx of the result, 0 = most significant.
  function automatic logic [7:0] res_byte(input logic [RES_W-1:0] r, input int idx);
    logic [RES_W-1:0] sh;
    sh = r >> (8 * (2 - idx));
    return sh[7:0];
  endfunction

endpackage

// File: rtl/div_datapath.sv
// Restoring-divide datapath: remainder, numerator and quotient registers
// with load / step / round controls driven by div_sequencer.
module div_datapath
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             round,
  input  logic [15:0]      dividend,
  input  logic [7:0]       divisor,
  output logic [RES_W-1:0] quotient
);

  logic [8:0]       rem_reg;
  logic [RES_W-1:0] num_reg;
  logic [RES_W-1:0] quo_reg;

  logic [8:0] rem_shift;
  logic [8:0] rem_sub;
  logic       fits;
  logic       round_up;

  always_comb begin
    rem_shift = {rem_reg[7:0], num_reg[RES_W-1]};
    rem_sub   = rem_shift - {1'b0, divisor};
    fits      = rem_shift >= {1'b0, divisor};
    // Round half up: the discarded fraction is rem/divisor.
    round_up  = {rem_reg, 1'b0} >= {2'b00, divisor};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_reg <= '0;
      num_reg <= '0;
      quo_reg <= '0;
    end else if (load) begin
      rem_reg <= '0;
      num_reg <= {dividend, {FRAC_BITS{1'b0}}};
      quo_reg <= (divisor == 8'd0) ? DIV_ZERO_RESULT : '0;
    end else if (step) begin
      num_reg <= {num_reg[RES_W-2:0], 1'b0};
      rem_reg <= fits ? rem_sub : rem_shift;
      quo_reg <= {quo_reg[RES_W-2:0], fits};
    end else if (round && round_up) begin
      quo_reg <= quo_reg + 1'b1;
    end
  end

  assign quotient = quo_reg;

endmodule

// File: rtl/div_sequencer.sv
// Start/Ack launched sequencer: read operands, restoring divide, write result.
// Define DIV_ROUND_EN to add a round-half-up cycle after the divide.
module div_sequencer
  import div_pkg::*;
#(
  parameter int AW   = 8,
  parameter int ITER = 24
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  output logic          Ack,
  output logic          Busy,
  output logic [AW-1:0] MemAddr,
  input  logic [7:0]    MemRdData,
  output logic          MemWrEn,
  output logic [7:0]    MemWrData
);

  localparam int CW = $clog2(ITER + 1);

  div_state_e       state_reg, state_next;
  logic             start_q_reg;
  logic [15:0]      dvd_reg;
  logic [7:0]       dvs_reg;
  logic [CW-1:0]    cnt_reg;
  logic             load, step, round;
  logic [RES_W-1:0] quotient;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_reg   <= ST_IDLE;
      start_q_reg <= 1'b0;
      dvd_reg     <= '0;
      dvs_reg     <= '0;
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      start_q_reg <= Start;
      if (state_reg == ST_RD0) dvd_reg[15:8] <= MemRdData;
      if (state_reg == ST_RD1) dvd_reg[7:0]  <= MemRdData;
      if (state_reg == ST_RD2) dvs_reg       <= MemRdData;
      if (state_reg == ST_CHK) cnt_reg <= '0;
      else if (state_reg == ST_DIV) cnt_reg <= cnt_reg + 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    step       = 1'b0;
    round      = 1'b0;
    Ack        = 1'b0;
    Busy       = 1'b1;
    MemAddr    = '0;
    MemWrEn    = 1'b0;
    MemWrData  = '0;
    case (state_reg)
      ST_IDLE: begin
        Busy = 1'b0;
        if (start_q_reg && !Start) state_next = ST_RD0;
      end
      ST_RD0: begin
        MemAddr    = AW'(ADDR_DVD_HI);
        state_next = ST_RD1;
      end
      ST_RD1: begin
        MemAddr    = AW'(ADDR_DVD_LO);
        state_next = ST_RD2;
      end
      ST_RD2: begin
        MemAddr    = AW'(ADDR_DVS);
        state_next = ST_CHK;
      end
      ST_CHK: begin
        load       = 1'b1;
        state_next = (dvs_reg == 8'd0) ? ST_WR4 : ST_DIV;
      end
      ST_DIV: begin
        step = 1'b1;
        if (cnt_reg == CW'(ITER - 1)) begin
`ifdef DIV_ROUND_EN
          state_next = ST_RND;
`else
          state_next = ST_WR4;
`endif
        end
      end
`ifdef DIV_ROUND_EN
      ST_RND: begin
        round      = 1'b1;
        state_next = ST_WR4;
      end
`endif
      ST_WR4: begin
        MemAddr    = AW'(ADDR_RES0);
        MemWrEn    = 1'b1;
        MemWrData  = res_byte(quotient, 0);
        state_next = ST_WR5;
      end
      ST_WR5: begin
        MemAddr    = AW'(ADDR_RES0 + 1);
        MemWrEn    = 1'b1;
        MemWrData  = res_byte(quotient, 1);
        state_next = ST_WR6;
      end
      ST_WR6: begin
        MemAddr    = AW'(ADDR_RES0 + 2);
        MemWrEn    = 1'b1;
        MemWrData  = res_byte(quotient, 2);
        state_next = ST_DONE;
      end
      ST_DONE: begin
        Busy = 1'b0;
        Ack  = 1'b1;
        if (Start) state_next = ST_IDLE;
      end
      default: begin
        Busy       = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
    // A Start pulse while busy abandons the job.
    if (Busy && Start) state_next = ST_IDLE;
  end

  div_datapath u_datapath (
    .clk      (Clk),
    .rst_n    (Reset),
    .load     (load),
    .step     (step),
    .round    (round),
    .dividend (dvd_reg),
    .divisor  (dvs_reg),
    .quotient (quotient)
  );

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: cycle-level timeline model plus
// arithmetic reference for the result, randomized and directed jobs.
module tb_div_sequencer;

`ifdef DIV_ROUND_EN
  localparam int LAT_DIV = 32;
  localparam logic [23:0] LIT_385_6 = 24'h00402B;
`else
  localparam int LAT_DIV = 31;
  localparam logic [23:0] LIT_385_6 = 24'h00402A;
`endif

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic       Ack;
  logic       Busy;
  logic [7:0] MemAddr;
  logic [7:0] MemRdData;
  logic       MemWrEn;
  logic [7:0] MemWrData;

  logic [7:0] op_mem [4];
  logic [7:0] res_mem [4];
  int         wr_pulses = 0;

  int checks = 0;
  int errors = 0;

  // Timeline model: mk = cycle index within a job (1 = RD0), 0 = idle.
  int          mk   = 0;
  int          mlat = 1000;
  logic        msq  = 1'b0;
  logic [7:0]  mop [3];
  logic [23:0] mres = '0;

  always #5 Clk = ~Clk;

  assign MemRdData = (MemAddr < 8'd3) ? op_mem[MemAddr[1:0]] : 8'h00;

  div_sequencer #(.AW(8), .ITER(24)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Ack       (Ack),
    .Busy      (Busy),
    .MemAddr   (MemAddr),
    .MemRdData (MemRdData),
    .MemWrEn   (MemWrEn),
    .MemWrData (MemWrData)
  );

  function automatic logic [23:0] ref_div(input logic [15:0] a, input logic [7:0] b);
    longint n, q, r;
    if (b == 8'd0) return 24'hFFFFFF;
    n = longint'(a) * 256;
    q = n / longint'(b);
    r = n % longint'(b);
`ifdef DIV_ROUND_EN
    if (2 * r >= longint'(b)) q = q + 1;
`endif
    return 24'(q);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  always @(posedge Clk) begin
    if (Reset && MemWrEn) begin
      if (MemAddr >= 8'd4 && MemAddr <= 8'd6) res_mem[MemAddr[1:0]] = MemWrData;
      wr_pulses++;
    end
  end

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      mk  = 0;
      msq = 1'b0;
    end else begin
      if (mk >= 1 && mk <= 3) mop[mk-1] = op_mem[mk-1];
      if (mk == 3) begin
        mres = ref_div({mop[0], mop[1]}, mop[2]);
        mlat = (mop[2] == 8'd0) ? 7 : LAT_DIV;
      end
      if (mk == 0) begin
        if (msq && !Start) begin
          mk   = 1;
          mlat = 1000;
        end
      end else if (mk == mlat + 1) begin
        if (Start) mk = 0;
      end else if (Start) begin
        mk = 0;
      end else begin
        mk = mk + 1;
      end
      msq = Start;
    end
  end

  always @(negedge Clk) begin
    if (Reset) begin
      logic       eb, ea, ew;
      logic [7:0] eaddr, edata;
      logic [23:0] sh;
      int idx;
      eb = 0; ea = 0; ew = 0; eaddr = 0; edata = 0;
      if (mk >= 1 && mk <= 3) begin
        eb = 1;
        eaddr = 8'(mk - 1);
      end else if (mk >= 4 && mk <= mlat) begin
        eb = 1;
        if (mk >= mlat - 2) begin
          idx   = mk - (mlat - 2);
          ew    = 1;
          eaddr = 8'(4 + idx);
          sh    = mres >> (8 * (2 - idx));
          edata = sh[7:0];
        end
      end else if (mk == mlat + 1) begin
        ea = 1;
      end
      check("cyc_busy", Busy, eb);
      check("cyc_ack", Ack, ea);
      check("cyc_wren", MemWrEn, ew);
      check("cyc_addr", MemAddr, eaddr);
      check("cyc_wdata", MemWrData, edata);
    end
  end

  task automatic launch(input logic [15:0] a, input logic [7:0] b);
    op_mem[0] = a[15:8];
    op_mem[1] = a[7:0];
    op_mem[2] = b;
    Start = 1'b1;
    tick();
    tick();
    Start = 1'b0;
    tick();
  endtask

  task automatic run_job(input logic [15:0] a, input logic [7:0] b,
                         output logic [23:0] res, output int lat);
    logic was_done;
    int   w0;
    was_done = Ack;
    w0 = wr_pulses;
    op_mem[0] = a[15:8];
    op_mem[1] = a[7:0];
    op_mem[2] = b;
    Start = 1'b1;
    tick();
    if (was_done) check("ack_drop", Ack, 0);
    tick();
    Start = 1'b0;
    tick();
    lat = 0;
    while (!Ack && lat < 200) begin
      tick();
      lat++;
      if (lat == 6) begin
        op_mem[0] = 8'($urandom);
        op_mem[1] = 8'($urandom);
        op_mem[2] = 8'($urandom);
      end
    end
    check("ack_timeout", Ack, 1);
    check("wr_count", wr_pulses - w0, 3);
    res = {res_mem[0], res_mem[1], res_mem[2]};
    $display("JOB dividend=0x%04h divisor=0x%02h result=0x%06h latency=%0d", a, b, res, lat);
    check("result", res, ref_div(a, b));
    check("latency", lat, (b == 8'd0) ? 7 : LAT_DIV);
  endtask

  initial begin
    logic [23:0] res;
    int          lat, w0;
    logic [15:0] ra;
    logic [7:0]  rb;

    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    logic [23:0] res;
    int          lat, w0;
    logic [15:0] ra;
    logic [7:0]  rb;

    Reset = 1'b0;
    Start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      op_mem[i]  = 8'h00;
      res_mem[i] = 8'h00;
    end

    // Model pins
    check("ref_12800_25", ref_div(16'd12800, 8'd25), 24'h020000);
    check("ref_385_6", ref_div(16'd385, 8'd6), LIT_385_6);
    check("ref_ffff_1", ref_div(16'hFFFF, 8'd1), 24'hFFFF00);
    check("ref_div0", ref_div(16'd1234, 8'd0), 24'hFFFFFF);

    #12;
    check("rst_busy", Busy, 0);
    check("rst_ack", Ack, 0);
    check("rst_wren", MemWrEn, 0);
    check("rst_addr", MemAddr, 0);
    check("rst_wdata", MemWrData, 0);
    tick();
    Reset = 1'b1;

    // Start low or held high after reset: no launch
    repeat (4) tick();
    check("idle_low", Busy, 0);
    Start = 1'b1;
    repeat (5) tick();
    check("held_high", Busy, 0);
    $display("TXN start held high, busy=%0b", Busy);

    run_job(16'd12800, 8'd25, res, lat);
    check("lit_12800_25", res, 24'h020000);
    check("lit_lat_div", lat, LAT_DIV);
    run_job(16'd385, 8'd6, res, lat);
    check("lit_385_6", res, LIT_385_6);
    run_job(16'hFFFF, 8'd1, res, lat);
    check("lit_ffff_1", res, 24'hFFFF00);
    run_job(16'd1234, 8'd0, res, lat);
    check("lit_div0", res, 24'hFFFFFF);
    check("lit_lat_zero", lat, 7);

    // Abort on DIV cycle 10
    w0 = wr_pulses;
    launch(16'd385, 8'd6);
    repeat (13) tick();
    Start = 1'b1;
    tick();
    check("abort_busy", Busy, 0);
    check("abort_ack", Ack, 0);
    repeat (40) tick();
    check("abort_writes", wr_pulses - w0, 0);
    check("abort_ack_late", Ack, 0);
    $display("TXN abort on DIV cycle 10, writes=%0d", wr_pulses - w0);
    run_job(16'd385, 8'd6, res, lat);
    check("post_abort", res, LIT_385_6);

    // Reset mid-DIV
    w0 = wr_pulses;
    launch(16'd12800, 8'd25);
    repeat (10) tick();
    #1 Reset = 1'b0;
    #1;
    check("rdiv_busy", Busy, 0);
    check("rdiv_addr", MemAddr, 0);
    check("rdiv_wren", MemWrEn, 0);
    tick();
    tick();
    Reset = 1'b1;
    Start = 1'b0;
    repeat (40) tick();
    check("rdiv_writes", wr_pulses - w0, 0);
    $display("TXN reset mid-DIV, writes=%0d", wr_pulses - w0);

    // Reset mid-WR5
    w0 = wr_pulses;
    launch(16'd385, 8'd6);
    repeat (LAT_DIV - 2) tick();
    check("wr5_addr", MemAddr, 5);
    #1 Reset = 1'b0;
    #1;
    check("rwr_busy", Busy, 0);
    check("rwr_ack", Ack, 0);
    check("rwr_wren", MemWrEn, 0);
    check("rwr_addr", MemAddr, 0);
    check("rwr_wdata", MemWrData, 0);
    tick();
    Reset = 1'b1;
    Start = 1'b0;
    repeat (10) tick();
    check("rwr_writes", wr_pulses - w0, 1);
    $display("TXN reset mid-WR5, writes=%0d", wr_pulses - w0);
    run_job(16'd385, 8'd6, res, lat);
    check("post_reset", res, LIT_385_6);

    // Randomized back-to-back jobs
    for (int j = 0; j < 12; j++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      run_job(ra, rb, res, lat);
    end

    Start = 1'b1;
    tick();
    check("final_ack_drop", Ack, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Hardware sequencer for the program-1 fixed-point divide. It sits beside data memory and runs the full job once the `Start`/`Ack` handshake launches it: fetch operands, run an iterative restoring divide, write the result back, raise `Ack`. It computes the 16-bit dividend divided by the 8-bit divisor, giving an 8-fractional-bit, 24-bit result. It owns the data-memory port while busy.

## Interface
- `AW`, default 8: data-memory address width.
- `ITER`, default 24: quotient bits produced, one per cycle.
- `Clk`, input, 1 bit: single clock; all state on rising edge.
- `Reset`, input, 1 bit: asynchronous, active-low reset.
- `Start`, input, 1 bit: launch request; job begins on its 1->0 transition.
- `Ack`, output, 1 bit: job complete; level, held until next `Start` high.
- `Busy`, output, 1 bit: high in every state except IDLE and DONE.
- `MemAddr`, output, AW bits: data-memory address.
- `MemRdData`, input, 8 bits: data-memory read data; combinational, same cycle as `MemAddr`.
- `MemWrEn`, output, 1 bit: data-memory write strobe, one cycle per byte.
- `MemWrData`, output, 8 bits: data-memory write data.

## Operation
- Memory map:
  - `[0]` holds dividend[15:8].
  - `[1]` holds dividend[7:0].
  - `[2]` holds the divisor.
  - `[4]`, `[5]`, `[6]` receive result[23:16], result[15:8] and result[7:0].
- Function:
  - result = floor((dividend·256)/divisor), 24 bits. This never overflows; the maximum is 0xFFFF00.
  - divisor == 0 gives result 0xFFFFFF.
- States:
  - IDLE -> RD0 when `Start` is sampled 0 after having been sampled 1 (registered `start_q`).
  - RD0 -> RD1 -> RD2: each captures `MemRdData` at addresses 0, 1, 2.
  - CHK: divisor == 0 -> WR4 with result 0xFFFFFF. Otherwise load numerator {dividend, 8'h00}, clear remainder (9 bits) and bit counter, -> DIV.
  - DIV, ITER cycles, each cycle:
    - rem' = {rem[7:0], num[23]}.
    - If rem' >= divisor: subtract and shift in 1; else shift in 0.
    - Num shifts left.
    - Counter == ITER-1 -> WR4.
  - WR4 -> WR5 -> WR6: `MemWrEn`=1, addresses 4, 5, 6, MSB first.
  - DONE: `Ack`=1. `Start` high -> IDLE.
- Outputs:
  - `MemAddr` is 0 in IDLE and DONE.
  - `MemWrEn` is asserted only in WR4–WR6.
  - `MemWrData` is 0 outside writes.
- Abort: `Start` sampled 1 in any busy state -> IDLE next cycle. No further writes are issued, and `Ack` stays 0.
- Reset (async, any time):
  - state = IDLE and `start_q` = 0.
  - `Ack` = `Busy` = `MemWrEn` = 0; `MemAddr` = `MemWrData` = 0.
  - Datapath registers are cleared.
- `Start` held high continuously means no launch. A launch requires a 1->0 transition observed after reset.

## Timing
- Launch: RD0 is the first cycle after `Start` is sampled low.
- Nonzero divisor: RD0 to DONE entry is 3 + 1 + ITER + 3 = 31 cycles; `Ack` rises on cycle 32.
- Zero divisor: 3 + 1 + 3 = 7 cycles to DONE.
- Writes occur on three consecutive cycles; memory captures each on the rising edge at the end of its WR cycle.
- Operand bytes are sampled in RD0–RD2 only. Later memory changes do not affect the job.

## Configuration
- `DIV_ROUND_EN`:
  - Defined: add state RND after DIV, one extra cycle (31 -> 32 latency).
  - In RND: if 2·rem >= divisor, result increments by 1 (round half up). No overflow is possible, since max = 0xFFFF00 + 1.
  - Zero-divisor path is unchanged.
  - Undefined: truncation only, no RND state.

## Structure
- Package `div_pkg`:
  - state enum.
  - address constants: `ADDR_DVD_HI`=0, `ADDR_DVD_LO`=1, `ADDR_DVS`=2, `ADDR_RES0`=4.
  - `DIV_ZERO_RESULT`=24'hFFFFFF.
  - `FRAC_BITS`=8.
- Sub-module `div_datapath`: remainder, numerator and quotient registers plus step logic, with `load`/`step`/`round` controls.
- The FSM stays in `div_sequencer`.

## Test plan
- Dividend 12800, divisor 25 -> writes 0x02, 0x00, 0x00 to [4..6]; `Ack` 31 cycles after RD0.
- Dividend 385, divisor 6 -> 0x00402A. With `DIV_ROUND_EN` -> 0x00402B at 32 cycles.
- Dividend 0xFFFF, divisor 1 -> 0xFFFF00. Divisor 0 (any dividend) -> 0xFFFFFF, `Ack` after 7 cycles, no DIV cycles.
- `Start` reasserted on DIV cycle 10 -> IDLE, zero `MemWrEn` pulses. A new launch with 385/6 -> correct 0x00402A.
- `Reset` low mid-DIV and mid-WR5 -> all outputs 0 immediately (asynchronous), no further writes. A post-reset launch completes correctly.
- Back-to-back jobs via `Start` high then low from DONE -> second result correct, and `Ack` drops the cycle after `Start` is sampled high.
